// File: rtl/param_mux_rr.sv
// param_mux_rr: registered N-channel, W-bit multiplexer with valid/ready
// handshakes on every input channel and on the output.
//
// Selection modes:
//   mode=0  fixed: channel 'sel' is granted when it is valid (and in range).
//   mode=1  round-robin: first valid channel scanning from rr_ptr upwards,
//           wrapping at N_CH; rr_ptr moves past each channel it grants.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         enable; 0 blocks new accepts (a pending word still drains)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_valid   per-channel valid
//   in_data    packed data; channel k at [k*DATA_W +: DATA_W]
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_ch     channel index of out_data
//   out_ready  downstream accepts the word
//   out_parity XOR-reduction of the loaded word (only with
//              PARAM_MUX_RR_PARITY_EN defined)
//
// Handshake: a word moves across an interface on a rising clk edge where
// both valid and ready are 1. valid never waits for ready; in_ready
// depends on out_valid only through load_ok = !out_valid | out_ready, so
// a drain and a reload can happen on the same edge (1 word/cycle).

module param_mux_rr #(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
`ifdef PARAM_MUX_RR_PARITY_EN
    output logic                   out_parity,
`endif
    input  logic                   out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic [DATA_W-1:0] grant_data;
    logic              load_ok;
    logic              accept;

    // Round-robin scan split in two passes: the first valid channel at or
    // above rr_ptr wins; if there is none, every valid channel is below
    // rr_ptr and the lowest-numbered one is next in wrap-around order.
    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!hi_found && in_valid[k] && (SEL_W'(k) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(k);
            end
            if (!lo_found && in_valid[k]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(k);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mode) begin
            grant_valid = lo_found;
            grant       = hi_found ? hi_idx : lo_idx;
        end else begin
            // Loop compare keeps sel values >= N_CH from ever granting.
            for (int k = 0; k < N_CH; k++) begin
                if ((sel == SEL_W'(k)) && in_valid[k]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign load_ok = !out_valid || out_ready;
    // rst_n in the product forces in_ready low throughout reset.
    assign accept  = rst_n && en && load_ok && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            in_ready[k] = accept && (grant == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            if (mode) begin
                rr_ptr <= (int'(grant) == N_CH - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_valid && out_ready) begin
            // Drain only: data and channel hold their last values.
            out_valid <= 1'b0;
        end
    end

`ifdef PARAM_MUX_RR_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (accept) begin
            out_parity <= ^grant_data;
        end
    end
`endif

endmodule

// File: tb/tb_param_mux_rr.sv
// tb_param_mux_rr: directed bench for param_mux_rr (N_CH=4, DATA_W=8).
// Inputs change on the falling edge; registered outputs are sampled on the
// falling edge after the rising edge that produced them, and the
// combinational in_ready is checked 1 time unit after the inputs settle.

module tb_param_mux_rr;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_ready;
`ifdef PARAM_MUX_RR_PARITY_EN
    logic                   out_parity;
`endif

    param_mux_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef PARAM_MUX_RR_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [SEL_W+DATA_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic check_ready(input string tag, input logic [3:0] exp);
        #1;
        check_val(tag, 32'(in_ready), 32'(exp));
    endtask

    // Queue the hand-computed word, advance one edge, then compare the
    // output register against the front of the queue.
    task automatic tick_expect(input string tag, input logic [1:0] ch,
                               input logic [7:0] data);
        logic [SEL_W+DATA_W-1:0] w;
        exp_q.push_back({ch, data});
        tick();
        w = exp_q.pop_front();
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_ch"},    32'(out_ch),    32'(w[DATA_W +: SEL_W]));
        check_val({tag, "_data"},  32'(out_data),  32'(w[DATA_W-1:0]));
    endtask

    task automatic check_idle(input string tag, input logic [1:0] ch,
                              input logic [7:0] data);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_ch"},    32'(out_ch),    32'(ch));
        check_val({tag, "_data"},  32'(out_data),  32'(data));
    endtask

    logic [1:0] rr_seq[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] ch_data[4] = '{8'h10, 8'h21, 8'hA5, 8'h37};

    initial begin
        // Reset held two edges with every channel requesting.
        rst_n     = 1'b0;
        en        = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(8'h10, 8'h21, 8'hA5, 8'h37);
        tick();
        tick();
        check_idle("rst", 2'd0, 8'h00);
        check_ready("rst_ready", 4'b0000);
`ifdef PARAM_MUX_RR_PARITY_EN
        check_val("rst_parity", 32'(out_parity), 32'd0);
`endif

        // Round-robin over all four channels, one word per cycle.
        rst_n = 1'b1;
        check_ready("rr_first_ready", 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick_expect($sformatf("rr%0d", i), rr_seq[i], ch_data[rr_seq[i]]);
        end

        // Sparse requests from rr_ptr=0: grants 1,3,1.
        in_valid = 4'b1010;
        check_ready("rr_sparse_ready", 4'b0010);
        tick_expect("rr_sp0", 2'd1, 8'h21);
        tick_expect("rr_sp1", 2'd3, 8'h37);
        tick_expect("rr_sp2", 2'd1, 8'h21);

        // Back-pressure: output word from ch1 must hold, no ready granted.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        check_ready("bp_ready", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick_expect($sformatf("bp%0d", i), 2'd1, 8'h21);
            check_ready($sformatf("bp%0d_ready", i), 4'b0000);
        end
        out_ready = 1'b1;
        check_ready("bp_release_ready", 4'b0100);
        tick_expect("bp_release", 2'd2, 8'hA5);

        // Enable low: pending word drains, nothing new accepted.
        en = 1'b0;
        check_ready("en0_ready", 4'b0000);
        tick();
        check_idle("en0_drain", 2'd2, 8'hA5);
        tick();
        check_idle("en0_hold", 2'd2, 8'hA5);
        en = 1'b1;
        check_ready("en1_ready", 4'b1000);
        tick_expect("en1", 2'd3, 8'h37);

        // Fixed mode on ch2, then select an idle channel.
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        check_ready("fix_ready", 4'b0100);
        tick_expect("fix", 2'd2, 8'hA5);
        sel = 2'd3;
        check_ready("fix_idle_ready", 4'b0000);
        tick();
        check_idle("fix_idle", 2'd2, 8'hA5);

        // Back to RR: fixed-mode accept must not have moved rr_ptr (0).
        mode     = 1'b1;
        in_valid = 4'b1111;
        check_ready("mode_sw_ready", 4'b0001);
        tick_expect("mode_sw", 2'd0, 8'h10);

        // Reset while a word is pending and stalled.
        out_ready = 1'b0;
        rst_n     = 1'b0;
        check_ready("rst_mid_ready", 4'b0000);
        tick();
        check_idle("rst_mid", 2'd0, 8'h00);

        // Parity words 0x07 (odd) and 0x03 (even).
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0011;
        set_data(8'h07, 8'h03, 8'h00, 8'h00);
        tick_expect("par0", 2'd0, 8'h07);
`ifdef PARAM_MUX_RR_PARITY_EN
        check_val("par0_parity", 32'(out_parity), 32'd1);
`endif
        tick_expect("par1", 2'd1, 8'h03);
`ifdef PARAM_MUX_RR_PARITY_EN
        check_val("par1_parity", 32'(out_parity), 32'd0);
`endif
        in_valid = 4'b0001;
        tick_expect("par2", 2'd0, 8'h07);
        rst_n = 1'b0;
        tick();
        check_idle("par_rst", 2'd0, 8'h00);
`ifdef PARAM_MUX_RR_PARITY_EN
        check_val("par_rst_parity", 32'(out_parity), 32'd0);
`endif

        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/param_mux_rr.md
Name: param_mux_rr

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed (external select) and round-robin (internal fair pointer).
- Global enable gates new selections.
- Sits in the combinational/datapath library as the sequential, multi-bit, N-way generalisation of the 4:1 enabled bit mux.

Parameters:
N_CH, 4, number of input channels (>=2)
DATA_W, 8, width of each channel's data word
SEL_W, $clog2(N_CH), width of select and channel-id fields (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  enable; 0 blocks new accepts
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_valid  input  N_CH  per-channel valid
in_data  input  N_CH*DATA_W  packed data; channel k at [k*DATA_W +: DATA_W]
in_ready  output  N_CH  per-channel ready (combinational)
out_valid  output  1  output register holds a word
out_data  output  DATA_W  registered selected word
out_ch  output  SEL_W  channel index of out_data
out_ready  input  1  downstream accepts word

Behaviour:
- Reset: sampled on the rising clk edge with rst_n=0.
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is forced to all 0 while rst_n=0.
- Output stage: single-entry register, load_ok = !out_valid | out_ready.
- Grant, combinational:
  - Fixed mode: grant = sel if in_valid[sel]=1 and sel < N_CH; otherwise no grant.
  - RR mode: grant = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH; no grant if all in_valid=0.
- in_ready[k] = en & load_ok & grant_valid & (k==grant).
  - At most one bit of in_ready is set.
  - in_ready never depends on out_valid of the same cycle except through load_ok.
- Accept (transfer on channel k): in_valid[k] & in_ready[k] at a clk edge.
  - Effect: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- Drain without accept: out_valid & out_ready with no accept, so out_valid <= 0; out_data and out_ch hold their last values.
- Simultaneous drain and accept: the register reloads and out_valid stays 1, giving full throughput of 1 word/cycle.
- Back-pressure: out_valid=1 & out_ready=0 gives all in_ready=0; out_data and out_ch are stable.
- rr_ptr:
  - On an accept in RR mode, rr_ptr <= (grant==N_CH-1) ? 0 : grant+1.
  - Unchanged otherwise, including accepts in fixed mode.
  - A mode switch takes effect on the next cycle's grant; rr_ptr is not reset.
- en=0: no new accepts, but a pending output word still drains normally.
- Latency: input to out_valid is 1 cycle.
- Reset mid-transfer: a pending word is discarded; out_valid=0 on the next cycle regardless of out_ready.
- Non-power-of-2 N_CH: indices >= N_CH are never granted or reported.

Optional Feature:
- Macro: PARAM_MUX_RR_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduction of the word loaded into out_data.
  - Registered on the same accept as out_data; reset value 0.
  - Holds its value across drains.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=0000; after release with en=1, mode=1, out_ready=1 -> first accept is ch0.
- Fixed mode: mode=0, sel=2, en=1, in_valid=0100, in_data ch2=0xA5, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=0xA5, out_ch=2; with sel=3 and in_valid[3]=0 -> no accept, out_valid falls to 0.
- Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1, one word per cycle; in_valid=1010 from rr_ptr=0 -> grants 1,3,1.
- Back-pressure: out_valid=1, out_ch=1, out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000 and out_data/out_ch stable; out_ready=1 -> next grant goes to ch2.
- Enable and drain: en=0 with out_valid=1, out_ready=1 -> out_valid falls to 0 next cycle, no new accepts while en=0; en=1 resumes in the following cycle.
- Parity (PARAM_MUX_RR_PARITY_EN defined): accept 0x07 -> out_parity=1; accept 0x03 -> out_parity=0; reset -> out_parity=0.
